// File: rtl/capture_trigger_ctrl_if.sv
// Button-to-frame-writer capture handshake bundle.
// The conditioning/writer side drives the inputs; the controller drives the outputs.
interface capture_trigger_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             trig_in;
    logic             vsync;
    logic             cap_ack;
    logic             cap_done;
    logic             cap_req;
    logic             busy;
    logic             err;
    logic [CNT_W-1:0] frame_cnt;

    modport master (
        output trig_in, vsync, cap_ack, cap_done,
        input  cap_req, busy, err, frame_cnt
    );

    modport slave (
        input  trig_in, vsync, cap_ack, cap_done,
        output cap_req, busy, err, frame_cnt
    );
endinterface

// File: rtl/capture_trigger_ctrl.sv
// Turns each button press into one frame-aligned capture request.
// It then runs the req/ack/done handshake, counts captures and aborts stalled states.
module capture_trigger_ctrl #(
    parameter logic        TRIG_ACTIVE = 1'b0,
    parameter logic [25:0] TIMEOUT_CYC = 26'd50000000,
    parameter int          CNT_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    capture_trigger_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_REQ  = 2'd2,
        ST_CAPT = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             r_trig_q;
    logic             r_vsync_q;
    logic [25:0]      r_tmo_cnt;
    logic             r_cap_req;
    logic             r_busy;
    logic             r_err;
    logic [CNT_W-1:0] r_frame_cnt;

    logic             w_trig_edge;
    logic             w_vs_edge;
    logic             w_tmo_hit;
    logic             w_abort;
    logic [25:0]      w_tmo_cnt_nxt;
    logic             w_cap_req_nxt;
    logic             w_busy_nxt;
    logic             w_err_nxt;
    logic [CNT_W-1:0] w_frame_cnt_nxt;

    assign w_trig_edge = (r_trig_q != TRIG_ACTIVE) && (bus.trig_in == TRIG_ACTIVE);
    assign w_vs_edge   = bus.vsync && !r_vsync_q;
    assign w_tmo_hit   = (r_tmo_cnt == TIMEOUT_CYC);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; the exit event of a state always wins over its timeout.
    always_comb begin
        w_next_state = r_state;
        w_abort      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_trig_edge) begin
                    w_next_state = ST_ARM;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_ARM: begin
                if (w_vs_edge) begin
                    w_next_state = ST_REQ;
                end else if (w_tmo_hit) begin
                    w_next_state = ST_IDLE;
                    w_abort      = 1'b1;
                end else begin
                    w_next_state = ST_ARM;
                end
            end
            ST_REQ: begin
                if (bus.cap_ack) begin
                    w_next_state = ST_CAPT;
                end else if (w_tmo_hit) begin
                    w_next_state = ST_IDLE;
                    w_abort      = 1'b1;
                end else begin
                    w_next_state = ST_REQ;
                end
            end
            ST_CAPT: begin
                if (bus.cap_done) begin
                    w_next_state = ST_IDLE;
                end else if (w_tmo_hit) begin
                    w_next_state = ST_IDLE;
                    w_abort      = 1'b1;
                end else begin
                    w_next_state = ST_CAPT;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Output/datapath next values, computed from the upcoming state so outputs are registered.
    always_comb begin
        w_cap_req_nxt   = (w_next_state == ST_REQ);
        w_busy_nxt      = (w_next_state != ST_IDLE);
        w_err_nxt       = r_err;
        w_frame_cnt_nxt = r_frame_cnt;
        w_tmo_cnt_nxt   = 26'd0;
        if ((r_state == ST_IDLE) && w_trig_edge) begin
            w_err_nxt = 1'b0;
        end else if (w_abort) begin
            w_err_nxt = 1'b1;
        end else begin
            w_err_nxt = r_err;
        end
        if ((r_state == ST_CAPT) && bus.cap_done) begin
            w_frame_cnt_nxt = r_frame_cnt + CNT_W'(1);
        end else begin
            w_frame_cnt_nxt = r_frame_cnt;
        end
        if (w_next_state != r_state) begin
            w_tmo_cnt_nxt = 26'd0;
        end else if (r_state != ST_IDLE) begin
            w_tmo_cnt_nxt = r_tmo_cnt + 26'd1;
        end else begin
            w_tmo_cnt_nxt = 26'd0;
        end
    end

    // Edge-detect history and the per-state timeout counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_trig_q  <= ~TRIG_ACTIVE;
            r_vsync_q <= 1'b1;
            r_tmo_cnt <= 26'd0;
        end else begin
            r_trig_q  <= bus.trig_in;
            r_vsync_q <= bus.vsync;
            r_tmo_cnt <= w_tmo_cnt_nxt;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cap_req   <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_cap_req   <= w_cap_req_nxt;
            r_busy      <= w_busy_nxt;
            r_err       <= w_err_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
        end
    end

    assign bus.cap_req   = r_cap_req;
    assign bus.busy      = r_busy;
    assign bus.err       = r_err;
    assign bus.frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_capture_trigger_ctrl.sv
// Directed bench for capture_trigger_ctrl: a vector table plus hand-written multi-cycle sequences.
module tb_capture_trigger_ctrl;

    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    capture_trigger_ctrl_if #(.CNT_W(CNT_W)) bus ();

    capture_trigger_ctrl #(
        .TRIG_ACTIVE (1'b0),
        .TIMEOUT_CYC (26'd20),
        .CNT_W       (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic t;
        logic v;
        logic a;
        logic d;
        logic req;
        logic busy;
        logic err;
        int   cnt;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // One clock with the given inputs; returns 1 ns after the edge.
    task automatic cyc(input logic t, input logic v, input logic a, input logic d);
        bus.trig_in  = t;
        bus.vsync    = v;
        bus.cap_ack  = a;
        bus.cap_done = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic vs);
        bus.trig_in  = 1'b1;
        bus.vsync    = vs;
        bus.cap_ack  = 1'b0;
        bus.cap_done = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int nrise;
        logic prev_req;

        // Rows: trig, vsync, ack, done -> cap_req, busy, err, frame_cnt after the edge.
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1};
        tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2};

        // Reset values.
        do_reset(1'b0);
        chk("rst_req",  int'(bus.cap_req), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_err",  int'(bus.err), 0);
        chk("rst_cnt",  int'(bus.frame_cnt), 0);

        // Nominal timeline: press at 10, vsync rises at 30, ack at 33, done at 50.
        for (int c = 0; c < 56; c++) begin
            cyc(((c >= 10) && (c < 13)) ? 1'b0 : 1'b1,
                ((c >= 30) && (c < 40)) ? 1'b1 : 1'b0,
                (c == 33) ? 1'b1 : 1'b0,
                (c == 50) ? 1'b1 : 1'b0);
            chk($sformatf("nom_busy@%0d", c + 1), int'(bus.busy),
                ((c + 1 >= 11) && (c + 1 <= 50)) ? 1 : 0);
            chk($sformatf("nom_req@%0d", c + 1), int'(bus.cap_req),
                ((c + 1 >= 31) && (c + 1 <= 33)) ? 1 : 0);
            chk($sformatf("nom_cnt@%0d", c + 1), int'(bus.frame_cnt), (c + 1 >= 51) ? 1 : 0);
        end

        // Vector table.
        do_reset(1'b0);
        for (int i = 0; i < 17; i++) begin
            cyc(tbl[i].t, tbl[i].v, tbl[i].a, tbl[i].d);
            chk($sformatf("tbl%0d_req", i),  int'(bus.cap_req), int'(tbl[i].req));
            chk($sformatf("tbl%0d_busy", i), int'(bus.busy), int'(tbl[i].busy));
            chk($sformatf("tbl%0d_err", i),  int'(bus.err), int'(tbl[i].err));
            chk($sformatf("tbl%0d_cnt", i),  int'(bus.frame_cnt), tbl[i].cnt);
        end

        // Long press of 200 cycles gives exactly one capture.
        do_reset(1'b0);
        nrise = 0;
        prev_req = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i < 200; i++) begin
            cyc(1'b0, ((i >= 5) && (i < 8)) ? 1'b1 : 1'b0, (i == 9) ? 1'b1 : 1'b0,
                (i == 14) ? 1'b1 : 1'b0);
            if (bus.cap_req && !prev_req) nrise++;
            prev_req = bus.cap_req;
        end
        chk("long_req_pulses", nrise, 1);
        chk("long_cnt", int'(bus.frame_cnt), 1);
        chk("long_busy", int'(bus.busy), 0);
        // Second press, with an extra press during CAPT that must be dropped.
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk("second_cnt", int'(bus.frame_cnt), 2);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("capt_press_ignored_busy", int'(bus.busy), 0);
        chk("capt_press_ignored_cnt", int'(bus.frame_cnt), 2);

        // Timeout in ARM: IDLE 21 cycles after entry, err set.
        do_reset(1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (20) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("tmo_arm_still_busy", int'(bus.busy), 1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("tmo_arm_busy", int'(bus.busy), 0);
        chk("tmo_arm_err", int'(bus.err), 1);
        chk("tmo_arm_cnt", int'(bus.frame_cnt), 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("retrig_err_clr", int'(bus.err), 0);
        chk("retrig_busy", int'(bus.busy), 1);
        // Timeout in REQ: ack never arrives, cap_req drops on abort.
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (20) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("tmo_req_still_req", int'(bus.cap_req), 1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("tmo_req_req", int'(bus.cap_req), 0);
        chk("tmo_req_busy", int'(bus.busy), 0);
        chk("tmo_req_err", int'(bus.err), 1);

        // Ack arriving in the same cycle as the timeout wins.
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (20) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk("ack_vs_tmo_busy", int'(bus.busy), 1);
        chk("ack_vs_tmo_req", int'(bus.cap_req), 0);
        chk("ack_vs_tmo_err", int'(bus.err), 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk("ack_vs_tmo_cnt", int'(bus.frame_cnt), 1);

        // vsync high through reset is not an edge.
        do_reset(1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("vs_hi_rst_busy", int'(bus.busy), 1);
        chk("vs_hi_rst_req", int'(bus.cap_req), 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("vs_hi_rst_req_after_edge", int'(bus.cap_req), 1);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);

        // 256 back-to-back captures wrap frame_cnt.
        do_reset(1'b0);
        for (int k = 0; k < 256; k++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            cyc(1'b1, 1'b1, 1'b0, 1'b0);
            cyc(1'b1, 1'b0, 1'b1, 1'b0);
            cyc(1'b1, 1'b0, 1'b0, 1'b1);
            if (k == 254) chk("wrap_cnt_255", int'(bus.frame_cnt), 255);
        end
        chk("wrap_cnt_0", int'(bus.frame_cnt), 0);

        // Async reset while requesting.
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("pre_arst_req", int'(bus.cap_req), 1);
        chk("pre_arst_cnt", int'(bus.frame_cnt), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_req_async", int'(bus.cap_req), 0);
        chk("arst_busy_async", int'(bus.busy), 0);
        #2;
        rst = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("post_arst_busy", int'(bus.busy), 0);
        chk("post_arst_cnt", int'(bus.frame_cnt), 0);
        chk("post_arst_req", int'(bus.cap_req), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
